game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Game countdown timer for the intercept game, clocked by the 50 MHz board clock.
- Consumes the divided ~10 Hz toggling signal from the clock divider. Every transition of that signal is one tenth-second tick.
- Counts game time down from START_SEC.0 in tenths, supports pause and bonus-time credit.
- Drives three BCD digits (tens of seconds, seconds, tenths) to the 7-segment display logic, plus status flags.

Parameters:
- START_SEC, 60, game duration in seconds, legal 1..99.
- BONUS_SEC, 5, seconds credited per bonus pulse, legal 0..99.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- slow_clk  in  1  divided clock from the divider, asynchronous to this block's sampling; each edge = 1 tick
- start  in  1  one-cycle pulse: load START_SEC.0 and begin counting
- pause  in  1  level: while high, counting is frozen
- bonus  in  1  one-cycle pulse: add BONUS_SEC seconds
- sec_tens  out  4  BCD tens-of-seconds digit
- sec_ones  out  4  BCD seconds digit
- tenths  out  4  BCD tenths digit
- running  out  1  high while in RUN
- done  out  1  high while in DONE
- time_up  out  1  one-cycle pulse on RUN->DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - sync regs s1, s2, s3 = 0; state = IDLE; count = 0.
  - All outputs 0: digits 0/0/0, running = 0, done = 0, time_up = 0.
  - Reset mid-game aborts immediately. No tick or pulse survives reset.
- Tick generation:
  - s1 <= slow_clk, s2 <= s1, s3 <= s2.
  - tick = s2 XOR s3, so both rising and falling edges count.
  - count update happens on the 3rd rising clk edge after a slow_clk transition.
- Count register:
  - 10-bit binary, units of 0.1 s, range 0..999.
  - Digits are combinationally decoded from count in the same cycle: sec_tens = count/100, sec_ones = (count/10)%10, tenths = count%10.
- States: IDLE, RUN, PAUSE, DONE.
- start has highest priority in every state:
  - count <= START_SEC*10.
  - Next state is PAUSE if pause=1, else RUN.
  - Any tick or bonus in the same cycle is dropped.
  - A start in RUN or PAUSE restarts the game.
- IDLE: hold count; ignore tick and bonus.
- RUN:
  - pause=1: next state PAUSE; a tick in the same cycle is dropped; a bonus is still applied.
  - Otherwise: count_next = min(count - tick + 10*bonus*BONUS_SEC, 999). Subtract first, then add, then saturate.
  - If count_next == 0: next state DONE, time_up = 1 for exactly that cycle (registered, asserted the cycle the state becomes DONE).
  - Bonus in the same cycle as the final tick keeps count > 0, so no DONE.
- PAUSE:
  - Ticks ignored.
  - bonus applies: count = min(count + 10*BONUS_SEC, 999).
  - pause=0: next state RUN; ticks are counted from the following cycle.
- DONE: count = 0, done = 1; ignore tick, bonus and pause.
- Outputs: running = (state==RUN); done = (state==DONE). PAUSE drives neither.
- Saturation: count never exceeds 999 (99.9 s) and never underflows. count=0 in RUN is unreachable because START_SEC >= 1.

Test Plan:
1. Reset, then start (pause=0) -> digits 6/0/0, running=1. Toggle slow_clk 3 times (every 40 clk) -> 5/9/7, each decrement exactly 3 clk after its edge.
2. START_SEC=1, start, 10 slow_clk edges -> digits go 0/0/1 to 0/0/0, time_up high exactly 1 cycle, done=1, running=0. An 11th edge leaves count at 0.
3. Running at 59.5, raise pause, 5 slow_clk edges -> digits stay 5/9/5, running=0. Drop pause, 1 edge -> 5/9/4.
4. Running at 97.0, bonus -> 99.9 (saturated). Bonus coincident with a tick at 10.0 -> 14.9.
5. At count 0.1, tick and bonus in the same cycle -> 5.0, state RUN, no time_up.
6. Assert reset low mid-game at 42.3 -> all outputs 0 immediately. Start while pause=1 -> 6/0/0, state PAUSE, running=0. Then a start in DONE restarts at 60.0.

Source files
------------

// File: rtl/game_countdown_timer_if.sv
// game_countdown_timer_if: control inputs and BCD/status outputs of the countdown timer.
interface game_countdown_timer_if;
   logic       slow_clk;
   logic       start;
   logic       pause;
   logic       bonus;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [3:0] tenths;
   logic       running;
   logic       done;
   logic       time_up;
   modport master (
      output slow_clk, start, pause, bonus,
      input  sec_tens, sec_ones, tenths, running, done, time_up
   );
   modport slave (
      input  slow_clk, start, pause, bonus,
      output sec_tens, sec_ones, tenths, running, done, time_up
   );
endinterface

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: tenth-second game countdown with pause, bonus credit and BCD digit outputs.
module game_countdown_timer #(
   parameter int START_SEC = 60,
   parameter int BONUS_SEC = 5
) (
   input logic                  clk,
   input logic                  reset,
   game_countdown_timer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   localparam logic [9:0]  START_CNT = 10'(START_SEC * 10);
   localparam logic [10:0] BONUS_CNT = 11'(BONUS_SEC * 10);
   state_t      state_q, state_d;
   logic [9:0]  count_q, count_d;
   logic [2:0]  sync_q;
   logic        time_up_q, time_up_d;
   logic        tick, dec_en;
   logic [10:0] sum;
   logic [9:0]  count_sat;
   // both edges of slow_clk count, seen after two synchronizer stages
   assign tick      = sync_q[1] ^ sync_q[2];
   assign dec_en    = tick && !bus.pause && state_q == RUN;
   assign sum       = 11'(count_q) - 11'(dec_en) + (bus.bonus ? BONUS_CNT : 11'd0);
   assign count_sat = sum > 11'd999 ? 10'd999 : sum[9:0];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         state_q   <= IDLE;
         count_q   <= '0;
         time_up_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[1:0], bus.slow_clk};
         state_q   <= state_d;
         count_q   <= count_d;
         time_up_q <= time_up_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      time_up_d = 1'b0;
      if (bus.start) begin
         count_d = START_CNT;
         state_d = bus.pause ? PAUSE : RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               count_d   = count_sat;
               time_up_d = count_sat == 10'd0;
               state_d   = count_sat == 10'd0 ? DONE : bus.pause ? PAUSE : RUN;
            end
            PAUSE: begin
               count_d = count_sat;
               state_d = bus.pause ? PAUSE : RUN;
            end
            DONE:    count_d = '0;
            default: ;
         endcase
      end
   end
   assign bus.sec_tens = 4'(count_q / 10'd100);
   assign bus.sec_ones = 4'((count_q / 10'd10) % 10'd10);
   assign bus.tenths   = 4'(count_q % 10'd10);
   assign bus.running  = state_q == RUN;
   assign bus.done     = state_q == DONE;
   assign bus.time_up  = time_up_q;
endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: directed checks of countdown, pause, bonus, saturation, DONE and reset.
module tb_game_countdown_timer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   game_countdown_timer_if ifa ();
   game_countdown_timer_if ifb ();
   game_countdown_timer #(.START_SEC(60), .BONUS_SEC(5)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
   game_countdown_timer #(.START_SEC(1),  .BONUS_SEC(5)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
   logic [11:0] d_a, d_b;
   assign d_a = {ifa.sec_tens, ifa.sec_ones, ifa.tenths};
   assign d_b = {ifb.sec_tens, ifb.sec_ones, ifb.tenths};
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick_a(input int n);
      repeat (n) begin
         ifa.slow_clk = ~ifa.slow_clk;
         cyc(4);
      end
   endtask

   task automatic tick_b(input int n);
      repeat (n) begin
         ifb.slow_clk = ~ifb.slow_clk;
         cyc(4);
      end
   endtask

   task automatic pulse_a_start();
      ifa.start = 1'b1;
      cyc(1);
      ifa.start = 1'b0;
   endtask

   task automatic pulse_a_bonus();
      ifa.bonus = 1'b1;
      cyc(1);
      ifa.bonus = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cyc(2);
      checks++; if (d_a !== 12'h000) begin failures++; $display("FAIL reset_digits_a got %h exp 000", d_a); end
      checks++; if ({ifa.running, ifa.done, ifa.time_up} !== 3'b000) begin failures++; $display("FAIL reset_flags_a got %b exp 000", {ifa.running, ifa.done, ifa.time_up}); end
      checks++; if (d_b !== 12'h000) begin failures++; $display("FAIL reset_digits_b got %h exp 000", d_b); end
      reset = 1'b1;
      cyc(1);
      tick_a(1);
      pulse_a_bonus();
      cyc(1);
      checks++; if (d_a !== 12'h000 || ifa.running !== 1'b0) begin failures++; $display("FAIL idle_ignore got %h run %b exp 000 run 0", d_a, ifa.running); end
   endtask

   task automatic test_countdown();
      logic [11:0] exp_v [3] = '{12'h599, 12'h598, 12'h597};
      logic [11:0] prev;
      pulse_a_start();
      checks++; if (d_a !== 12'h600) begin failures++; $display("FAIL start_digits got %h exp 600", d_a); end
      checks++; if (ifa.running !== 1'b1) begin failures++; $display("FAIL start_running got %b exp 1", ifa.running); end
      prev = 12'h600;
      for (int i = 0; i < 3; i++) begin
         ifa.slow_clk = ~ifa.slow_clk;
         cyc(2);
         checks++; if (d_a !== prev) begin failures++; $display("FAIL tick_early%0d got %h exp %h", i, d_a, prev); end
         cyc(1);
         checks++; if (d_a !== exp_v[i]) begin failures++; $display("FAIL tick_on%0d got %h exp %h", i, d_a, exp_v[i]); end
         prev = exp_v[i];
         cyc(37);
      end
   endtask

   task automatic test_pause();
      tick_a(2);
      checks++; if (d_a !== 12'h595) begin failures++; $display("FAIL pre_pause got %h exp 595", d_a); end
      ifa.pause = 1'b1;
      cyc(1);
      tick_a(5);
      checks++; if (d_a !== 12'h595) begin failures++; $display("FAIL paused_hold got %h exp 595", d_a); end
      checks++; if (ifa.running !== 1'b0 || ifa.done !== 1'b0) begin failures++; $display("FAIL paused_flags got run %b done %b exp 0 0", ifa.running, ifa.done); end
      ifa.pause = 1'b0;
      cyc(1);
      checks++; if (ifa.running !== 1'b1) begin failures++; $display("FAIL unpause_running got %b exp 1", ifa.running); end
      tick_a(1);
      checks++; if (d_a !== 12'h594) begin failures++; $display("FAIL unpause_tick got %h exp 594", d_a); end
   endtask

   task automatic test_bonus();
      repeat (8) pulse_a_bonus();
      checks++; if (d_a !== 12'h994) begin failures++; $display("FAIL bonus_add got %h exp 994", d_a); end
      pulse_a_bonus();
      checks++; if (d_a !== 12'h999) begin failures++; $display("FAIL bonus_sat1 got %h exp 999", d_a); end
      tick_a(29);
      checks++; if (d_a !== 12'h970) begin failures++; $display("FAIL at_970 got %h exp 970", d_a); end
      pulse_a_bonus();
      checks++; if (d_a !== 12'h999) begin failures++; $display("FAIL bonus_sat2 got %h exp 999", d_a); end
      tick_a(899);
      checks++; if (d_a !== 12'h100) begin failures++; $display("FAIL at_100 got %h exp 100", d_a); end
      ifa.slow_clk = ~ifa.slow_clk;
      cyc(2);
      pulse_a_bonus();
      checks++; if (d_a !== 12'h149) begin failures++; $display("FAIL tick_bonus got %h exp 149", d_a); end
      checks++; if (ifa.running !== 1'b1) begin failures++; $display("FAIL tick_bonus_run got %b exp 1", ifa.running); end
   endtask

   task automatic test_done();
      ifb.start = 1'b1;
      cyc(1);
      ifb.start = 1'b0;
      checks++; if (d_b !== 12'h010) begin failures++; $display("FAIL b_start got %h exp 010", d_b); end
      tick_b(9);
      checks++; if (d_b !== 12'h001) begin failures++; $display("FAIL b_at_001 got %h exp 001", d_b); end
      ifb.slow_clk = ~ifb.slow_clk;
      cyc(2);
      checks++; if (ifb.time_up !== 1'b0 || d_b !== 12'h001) begin failures++; $display("FAIL pre_final got %h tu %b exp 001 tu 0", d_b, ifb.time_up); end
      cyc(1);
      checks++; if (d_b !== 12'h000) begin failures++; $display("FAIL final_digits got %h exp 000", d_b); end
      checks++; if ({ifb.running, ifb.done, ifb.time_up} !== 3'b011) begin failures++; $display("FAIL final_flags got %b exp 011", {ifb.running, ifb.done, ifb.time_up}); end
      cyc(1);
      checks++; if ({ifb.done, ifb.time_up} !== 2'b10) begin failures++; $display("FAIL time_up_width got %b exp 10", {ifb.done, ifb.time_up}); end
      tick_b(1);
      ifb.bonus = 1'b1;
      cyc(1);
      ifb.bonus = 1'b0;
      checks++; if (d_b !== 12'h000 || ifb.done !== 1'b1) begin failures++; $display("FAIL done_hold got %h done %b exp 000 1", d_b, ifb.done); end
   endtask

   task automatic test_last_tick_bonus();
      ifb.start = 1'b1;
      cyc(1);
      ifb.start = 1'b0;
      tick_b(9);
      checks++; if (d_b !== 12'h001) begin failures++; $display("FAIL b2_at_001 got %h exp 001", d_b); end
      ifb.slow_clk = ~ifb.slow_clk;
      cyc(2);
      ifb.bonus = 1'b1;
      cyc(1);
      ifb.bonus = 1'b0;
      checks++; if (d_b !== 12'h050) begin failures++; $display("FAIL last_bonus got %h exp 050", d_b); end
      checks++; if ({ifb.running, ifb.done, ifb.time_up} !== 3'b100) begin failures++; $display("FAIL last_bonus_flags got %b exp 100", {ifb.running, ifb.done, ifb.time_up}); end
   endtask

   task automatic test_reset_midgame();
      repeat (6) pulse_a_bonus();
      tick_a(26);
      checks++; if (d_a !== 12'h423) begin failures++; $display("FAIL at_423 got %h exp 423", d_a); end
      reset = 1'b0;
      #1;
      checks++; if (d_a !== 12'h000) begin failures++; $display("FAIL async_reset_digits got %h exp 000", d_a); end
      checks++; if ({ifa.running, ifa.done, ifa.time_up} !== 3'b000) begin failures++; $display("FAIL async_reset_flags got %b exp 000", {ifa.running, ifa.done, ifa.time_up}); end
      cyc(1);
      reset = 1'b1;
      cyc(4);
      ifa.pause = 1'b1;
      pulse_a_start();
      checks++; if (d_a !== 12'h600 || ifa.running !== 1'b0 || ifa.done !== 1'b0) begin failures++; $display("FAIL start_paused got %h run %b done %b exp 600 0 0", d_a, ifa.running, ifa.done); end
      tick_a(2);
      checks++; if (d_a !== 12'h600) begin failures++; $display("FAIL start_paused_hold got %h exp 600", d_a); end
      ifa.pause = 1'b0;
      cyc(1);
      tick_a(600);
      checks++; if (d_a !== 12'h000 || ifa.done !== 1'b1) begin failures++; $display("FAIL a_done got %h done %b exp 000 1", d_a, ifa.done); end
      pulse_a_start();
      checks++; if (d_a !== 12'h600 || ifa.running !== 1'b1 || ifa.done !== 1'b0) begin failures++; $display("FAIL restart_done got %h run %b done %b exp 600 1 0", d_a, ifa.running, ifa.done); end
   endtask

   initial begin
      {ifa.slow_clk, ifa.start, ifa.pause, ifa.bonus} = 4'b0;
      {ifb.slow_clk, ifb.start, ifb.pause, ifb.bonus} = 4'b0;
      test_reset();
      test_countdown();
      test_pause();
      test_bonus();
      test_done();
      test_last_tick_bonus();
      test_reset_midgame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
